// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared pipeline definitions used by the EX-stage hazard controller.
package ex_hazard_ctrl_pkg;

  // EX source-mux select codes
  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from resultW
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from aluresultM

  // resultsrc code marking a load instruction
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  // Multi-cycle mul/div sequencing states
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one EX source operand. MEM-stage results take
// priority over WB-stage results because they are younger, and x0 is
// never forwarded since it is hardwired to zero.
module fwd_sel
  import ex_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  output logic [1:0] sel
);

  // Priority match: M stage first, then W stage, else register file
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard and sequencing controller: operand forwarding,
// load-use stalls, branch/jump flushes and a start/done handshake with a
// multi-cycle mul/div unit guarded by a watchdog. Saturating stall and
// flush counters are kept for performance debug.
module ex_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic [1:0]       resultsrcE,
  input  logic             pcsrcE,
  input  logic             mdopE,
  input  logic             md_done,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import ex_hazard_ctrl_pkg::*;

  localparam int              WD_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

  md_state_e       state;
  md_state_e       next_state;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;
  logic            lwstall;
  logic            mdhold;

  // Forwarding selects for the two EX source operands
  fwd_sel u_fwd_a (
    .rs         (rs1E),
    .rd_m       (rdM),
    .rd_w       (rdW),
    .regwrite_m (regwriteM),
    .regwrite_w (regwriteW),
    .sel        (forwardAE)
  );

  fwd_sel u_fwd_b (
    .rs         (rs2E),
    .rd_m       (rdM),
    .rd_w       (rdW),
    .regwrite_m (regwriteM),
    .regwrite_w (regwriteW),
    .sel        (forwardBE)
  );

  // A load in EX whose destination feeds the instruction in decode
  assign lwstall = (resultsrcE == RESULTSRC_LOAD) && (rdE != 5'd0) &&
                   ((rdE == rs1D) || (rdE == rs2D));

  assign wd_expired = (wd_cnt == WD_LAST);

  // Mul/div next state, start pulse and EX hold. A taken branch beats a
  // mul/div op in IDLE so the op is never started. In BUSY the hold drops
  // on md_done or on watchdog expiry, letting the held op leave EX.
  always_comb begin
    next_state = state;
    md_start   = 1'b0;
    mdhold     = 1'b0;
    case (state)
      MD_IDLE: begin
        if (mdopE && !pcsrcE) begin
          md_start   = 1'b1;
          mdhold     = 1'b1;
          next_state = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (md_done || wd_expired) begin
          next_state = MD_IDLE;
        end else begin
          mdhold = 1'b1;
        end
      end
      default: next_state = MD_IDLE;
    endcase
  end

  assign stallF  = lwstall | mdhold;
  assign stallD  = lwstall | mdhold;
  assign stallE  = mdhold;
  assign flushM  = mdhold;
  assign flushD  = pcsrcE;
  assign flushE  = (lwstall | pcsrcE) & ~mdhold;
  assign md_busy = (state == MD_BUSY);

  // State register, watchdog count and sticky timeout flag
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MD_IDLE;
      wd_cnt <= '0;
      md_err <= 1'b0;
    end else begin
      state <= next_state;
      if (state == MD_IDLE) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if ((state == MD_BUSY) && !md_done && wd_expired) begin
        md_err <= 1'b1;
      end
    end
  end

  // Saturating performance counters for stall and flush cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallF && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flushD && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl. Inputs change 1 ns after a rising
// edge and outputs are sampled 1 ns later, well away from the next edge.
// Small counter width and watchdog limit make saturation and timeout
// reachable in a short run.
module tb_ex_hazard_ctrl;

  localparam int CNT_W      = 4;
  localparam int MD_TIMEOUT = 8;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic             regwriteM, regwriteW;
  logic [1:0]       resultsrcE;
  logic             pcsrcE, mdopE, md_done;
  logic [1:0]       forwardAE, forwardBE;
  logic             stallF, stallD, stallE;
  logic             flushD, flushE, flushM;
  logic             md_start, md_busy, md_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int tests  = 0;
  int failed = 0;

  ex_hazard_ctrl #(
    .CNT_W      (CNT_W),
    .MD_TIMEOUT (MD_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .rs1E       (rs1E),
    .rs2E       (rs2E),
    .rdE        (rdE),
    .rdM        (rdM),
    .rdW        (rdW),
    .regwriteM  (regwriteM),
    .regwriteW  (regwriteW),
    .resultsrcE (resultsrcE),
    .pcsrcE     (pcsrcE),
    .mdopE      (mdopE),
    .md_done    (md_done),
    .forwardAE  (forwardAE),
    .forwardBE  (forwardBE),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .flushD     (flushD),
    .flushE     (flushE),
    .flushM     (flushM),
    .md_start   (md_start),
    .md_busy    (md_busy),
    .md_err     (md_err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
    rdE = '0; rdM = '0; rdW = '0;
    regwriteM = 1'b0; regwriteW = 1'b0;
    resultsrcE = 2'b00;
    pcsrcE = 1'b0; mdopE = 1'b0; md_done = 1'b0;
  endtask

  // Global time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    // Reset state
    chk("rst_busy",  32'(md_busy),   32'd0);
    chk("rst_err",   32'(md_err),    32'd0);
    chk("rst_start", 32'(md_start),  32'd0);
    chk("rst_scnt",  32'(stall_cnt), 32'd0);
    chk("rst_fcnt",  32'(flush_cnt), 32'd0);
    chk("rst_stallF", 32'(stallF),   32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Forwarding: M beats W
    rs1E = 5'd5; rdM = 5'd5; rdW = 5'd5; regwriteM = 1'b1; regwriteW = 1'b1;
    #1 chk("fwdA_mem", 32'(forwardAE), 32'd2);
    regwriteM = 1'b0;
    #1 chk("fwdA_wb", 32'(forwardAE), 32'd1);
    // x0 is never forwarded from M; W does not match rs2E
    rs2E = 5'd0; rdM = 5'd0; regwriteM = 1'b1;
    #1 chk("fwdB_x0", 32'(forwardBE), 32'd0);
    // Both sources at x0 with every producer at x0
    rs1E = 5'd0; rdW = 5'd0;
    #1 chk("fwdA_x0", 32'(forwardAE), 32'd0);
    // B from M, A from W simultaneously
    rs1E = 5'd5; rdW = 5'd5; rs2E = 5'd9; rdM = 5'd9;
    #1 chk("fwdB_mem", 32'(forwardBE), 32'd2);
    chk("fwdA_wb2", 32'(forwardAE), 32'd1);
    clear_inputs();

    // Load-use hazard for one cycle
    next_cycle();
    resultsrcE = 2'b01; rdE = 5'd7; rs2D = 5'd7;
    #1 chk("lu_stallF", 32'(stallF), 32'd1);
    chk("lu_stallD", 32'(stallD), 32'd1);
    chk("lu_flushE", 32'(flushE), 32'd1);
    chk("lu_stallE", 32'(stallE), 32'd0);
    chk("lu_flushM", 32'(flushM), 32'd0);
    next_cycle();
    clear_inputs();
    #1 chk("lu_scnt", 32'(stall_cnt), 32'd1);
    chk("lu_release", 32'(stallF), 32'd0);
    // Load to x0 is no hazard
    resultsrcE = 2'b01; rdE = 5'd0; rs1D = 5'd0;
    #1 chk("lu_x0", 32'(stallF), 32'd0);
    clear_inputs();

    // Taken branch for one cycle
    pcsrcE = 1'b1;
    #1 chk("br_flushD", 32'(flushD), 32'd1);
    chk("br_flushE", 32'(flushE), 32'd1);
    chk("br_stallF", 32'(stallF), 32'd0);
    next_cycle();
    pcsrcE = 1'b0;
    #1 chk("br_fcnt", 32'(flush_cnt), 32'd1);
    chk("br_release", 32'(flushD), 32'd0);

    // Mul/div handshake, done in cycle 3
    mdopE = 1'b1;                               // cycle 0
    #1 chk("md0_start", 32'(md_start), 32'd1);
    chk("md0_stallE", 32'(stallE), 32'd1);
    chk("md0_flushM", 32'(flushM), 32'd1);
    chk("md0_stallF", 32'(stallF), 32'd1);
    chk("md0_flushE", 32'(flushE), 32'd0);
    chk("md0_busy",   32'(md_busy), 32'd0);
    next_cycle();                               // cycle 1
    chk("md1_start", 32'(md_start), 32'd0);
    chk("md1_busy",  32'(md_busy),  32'd1);
    chk("md1_stallE", 32'(stallE),  32'd1);
    next_cycle();                               // cycle 2
    chk("md2_flushM", 32'(flushM), 32'd1);
    next_cycle();                               // cycle 3
    md_done = 1'b1;
    #1 chk("md3_stallE", 32'(stallE), 32'd0);
    chk("md3_stallF", 32'(stallF), 32'd0);
    chk("md3_flushM", 32'(flushM), 32'd0);
    chk("md3_busy",   32'(md_busy), 32'd1);
    next_cycle();                               // cycle 4: back-to-back op
    md_done = 1'b0;
    #1 chk("md4_busy",  32'(md_busy),  32'd0);
    chk("md4_scnt",  32'(stall_cnt), 32'd4);
    chk("b2b_start", 32'(md_start),  32'd1);

    // Timeout: this op gets no md_done; start was cycle t0
    for (int i = 1; i <= 7; i++) next_cycle(); // t7
    chk("to7_busy", 32'(md_busy), 32'd1);
    chk("to7_err",  32'(md_err),  32'd0);
    next_cycle();                               // t8
    chk("to8_busy", 32'(md_busy), 32'd1);
    chk("to8_err",  32'(md_err),  32'd0);
    next_cycle();                               // t9
    mdopE = 1'b0;
    #1 chk("to9_err",  32'(md_err),  32'd1);
    chk("to9_busy", 32'(md_busy), 32'd0);
    chk("to9_start", 32'(md_start), 32'd0);

    // Long op with late done: stall counter saturates at 15
    next_cycle();
    mdopE = 1'b1;                               // u0
    #1 chk("u0_start", 32'(md_start), 32'd1);
    for (int i = 1; i <= 5; i++) next_cycle(); // u5
    chk("sat_scnt", 32'(stall_cnt), 32'd15);
    md_done = 1'b1;
    #1 chk("u5_stallE", 32'(stallE), 32'd0);
    next_cycle();
    md_done = 1'b0; mdopE = 1'b0;
    #1 chk("sat_hold", 32'(stall_cnt), 32'd15);
    chk("err_sticky", 32'(md_err), 32'd1);
    chk("u6_busy", 32'(md_busy), 32'd0);

    // mdopE together with pcsrcE: branch wins, no start
    mdopE = 1'b1; pcsrcE = 1'b1;
    #1 chk("mdbr_start",  32'(md_start), 32'd0);
    chk("mdbr_stallE", 32'(stallE),   32'd0);
    chk("mdbr_flushE", 32'(flushE),   32'd1);
    next_cycle();
    mdopE = 1'b0; pcsrcE = 1'b0;
    #1 chk("mdbr_busy", 32'(md_busy), 32'd0);
    chk("mdbr_fcnt", 32'(flush_cnt), 32'd2);

    // Reset during cycle 2 of a BUSY period
    mdopE = 1'b1;                               // v0
    #1 chk("v0_start", 32'(md_start), 32'd1);
    next_cycle();                               // v1
    next_cycle();                               // v2
    chk("v2_busy", 32'(md_busy), 32'd1);
    rst = 1'b1; mdopE = 1'b0;
    #1 chk("mrst_busy",  32'(md_busy),   32'd0);
    chk("mrst_scnt",  32'(stall_cnt), 32'd0);
    chk("mrst_fcnt",  32'(flush_cnt), 32'd0);
    chk("mrst_err",   32'(md_err),    32'd0);
    chk("mrst_start", 32'(md_start),  32'd0);
    next_cycle();
    rst = 1'b0;
    md_done = 1'b1;                             // late done in IDLE
    #1 chk("late_stallE", 32'(stallE),  32'd0);
    chk("late_busy",   32'(md_busy), 32'd0);
    next_cycle();
    md_done = 1'b0;
    #1 chk("late_busy2", 32'(md_busy),   32'd0);
    chk("late_err",   32'(md_err),    32'd0);
    chk("late_scnt",  32'(stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
